// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front end that reads the synchronous program ROM, assembles
// 1- or 2-byte instructions and hands them to execute over a valid/ready handshake.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   rom_address / rom_data     ROM address (always the PC) and ROM data (one-cycle latency)
//   ir_opcode/operand/pc       issued instruction, operand 8'h00 for 1-byte instructions
//   ir_valid / ir_ready        issue handshake
//   ir_illegal                 issued opcode is undefined (trap build only, else 0)
//   redirect_en/redirect_addr  branch redirect from execute
//   fetch_fault                sticky fault, left only through reset
// Optional feature macro: FETCH_ILLEGAL_TRAP_EN (undefined opcodes trap into the fault state).
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int          ROM_DEPTH = 128
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] rom_address,
    input  logic [7:0] rom_data,
    output logic [7:0] ir_opcode,
    output logic [7:0] ir_operand,
    output logic [7:0] ir_pc,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic       ir_illegal,
    input  logic       redirect_en,
    input  logic [7:0] redirect_addr,
    output logic       fetch_fault
);
    typedef enum logic [2:0] {FETCH_OP, CAPT_OP, FETCH_ARG, CAPT_ARG, ISSUE, FAULT} state_t;

    // one extra bit so a depth of 256 still compares correctly
    localparam logic [8:0] DEPTH = 9'(ROM_DEPTH);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic [7:0] ir_pc_q, ir_pc_d;
    logic       pc_oob, handshake, trap, redirect;

    function automatic logic is_two_byte(input logic [7:0] op);
        return (op inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97}) || (op >= 8'h20 && op <= 8'h28);
    endfunction

    assign pc_oob    = {1'b0, pc_q} >= DEPTH;
    assign handshake = ir_valid && ir_ready;

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign ir_illegal = ir_valid && !is_two_byte(opcode_q) && !(opcode_q >= 8'h42 && opcode_q <= 8'h4C);
`else
    assign ir_illegal = 1'b0;
`endif

    // an illegal instruction being consumed traps even if a redirect arrives with it
    assign trap     = handshake && ir_illegal;
    assign redirect = redirect_en && state_q != FAULT && !trap;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH_OP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_OP:  state_d = pc_oob ? FAULT : CAPT_OP;
            CAPT_OP:   state_d = is_two_byte(rom_data) ? FETCH_ARG : ISSUE;
            FETCH_ARG: state_d = pc_oob ? FAULT : CAPT_ARG;
            CAPT_ARG:  state_d = ISSUE;
            ISSUE:     state_d = !handshake ? ISSUE : (trap ? FAULT : FETCH_OP);
            FAULT:     state_d = FAULT;
            default:   state_d = FETCH_OP;
        endcase
        if (redirect) state_d = FETCH_OP;
    end

    always_comb begin
        ir_valid    = state_q == ISSUE;
        fetch_fault = state_q == FAULT;
    end

    // the PC advances past each byte as it is captured, so in ISSUE it already
    // points at the next instruction and holds there under backpressure
    always_comb begin
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ir_pc_d   = ir_pc_q;
        if (state_q == CAPT_OP) begin
            opcode_d  = rom_data;
            operand_d = 8'h00;
            ir_pc_d   = pc_q;
            pc_d      = pc_q + 8'd1;
        end
        if (state_q == CAPT_ARG) begin
            operand_d = rom_data;
            pc_d      = pc_q + 8'd1;
        end
        if (redirect) pc_d = redirect_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            ir_pc_q   <= 8'h00;
        end else begin
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ir_pc_q   <= ir_pc_d;
        end
    end

    assign rom_address = pc_q;
    assign ir_opcode   = opcode_q;
    assign ir_operand  = operand_q;
    assign ir_pc       = ir_pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and short random stimulus for instr_fetch_unit, checked
// every cycle against a timeline model of the fetch sequence plus literal expectations.
module tb_instr_fetch_unit;
`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b1, ir_ready = 1'b0, redirect_en = 1'b0;
    logic [7:0] redirect_addr = 8'h00, rom_data = 8'h00;
    logic [7:0] rom_address, ir_opcode, ir_operand, ir_pc;
    logic       ir_valid, ir_illegal, fetch_fault;
    logic [7:0] rom [0:127];
    logic [7:0] tbl [15] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h20, 8'h24,
                             8'h28, 8'h42, 8'h47, 8'h4C, 8'hFF, 8'h00, 8'h50};
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
        .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_illegal(ir_illegal),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr), .fetch_fault(fetch_fault)
    );

    always @(posedge clk) rom_data <= rom[rom_address[6:0]];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit two_b(input logic [7:0] o);
        return (o inside {8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97}) || (o >= 8'h20 && o <= 8'h28);
    endfunction

    function automatic bit undef_b(input logic [7:0] o);
        return !two_b(o) && !(o >= 8'h42 && o <= 8'h4C);
    endfunction

    // Model: instruction starts at m_s; m_k counts cycles since its fetch began.
    // A 1-byte instruction is presented from cycle 3, a 2-byte one from cycle 5.
    logic [7:0] m_s = 8'h00, m_faddr = 8'h00;
    int         m_k = 1;
    bit         m_flt = 1'b0, m_init = 1'b0;

    function automatic int m_len();
        return two_b(rom[m_s[6:0]]) ? 2 : 1;
    endfunction

    function automatic bit m_valid();
        return m_init && !m_flt && m_s < 8'h80 && m_k >= 2 * m_len() + 1;
    endfunction

    always @(posedge clk) begin
        int l;
        bit v;
        if (reset) begin
            m_s = 8'h00; m_k = 1; m_flt = 1'b0; m_init = 1'b1;
        end else if (m_init && !m_flt) begin
            l = m_len();
            v = m_valid();
            if (v && ir_ready && TRAP && undef_b(rom[m_s[6:0]])) begin
                m_flt = 1'b1; m_faddr = m_s + 8'd1;
            end else if (redirect_en) begin
                m_s = redirect_addr; m_k = 1;
            end else if (v && ir_ready) begin
                m_s = m_s + 8'(l); m_k = 1;
            end else if (m_k == 1 && m_s >= 8'h80) begin
                m_flt = 1'b1; m_faddr = m_s;
            end else if (m_k == 3 && l == 2 && {1'b0, m_s} + 9'd1 >= 9'h080) begin
                m_flt = 1'b1; m_faddr = m_s + 8'd1;
            end else if (!v) m_k++;
        end
    end

    always @(negedge clk) begin
        logic [7:0] ea, na;
        int l;
        if (m_init) begin
            l  = m_len();
            na = m_s + 8'd1;
            ea = m_flt ? m_faddr : (m_k <= 2 ? m_s : (m_k >= 2 * l + 1 ? m_s + 8'(l) : na));
            chk("rom_address", rom_address, ea);
            chk("ir_valid", 8'(ir_valid), 8'(m_valid()));
            chk("fetch_fault", 8'(fetch_fault), 8'(m_flt));
            chk("ir_illegal", 8'(ir_illegal), 8'(TRAP && m_valid() && undef_b(rom[m_s[6:0]])));
            if (m_valid()) begin
                chk("ir_opcode", ir_opcode, rom[m_s[6:0]]);
                chk("ir_operand", ir_operand, l == 2 ? rom[na[6:0]] : 8'h00);
                chk("ir_pc", ir_pc, m_s);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        redirect_en = 1'b0;
        cyc(1);
        for (int i = 0; i < 128; i++) rom[i] = 8'h42;
    endtask

    // leaves the bench in cycle 1 (first FETCH_OP) after reset
    task automatic run();
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic lit_issue(input string nm, input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc);
        chk({nm, "_valid"}, 8'(ir_valid), 8'd1);
        chk({nm, "_op"}, ir_opcode, op);
        chk({nm, "_arg"}, ir_operand, arg);
        chk({nm, "_pc"}, ir_pc, pc);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'h42;
        // fetch sequence and reset values
        hold_reset();
        rom[0] = 8'h86; rom[1] = 8'h01; rom[2] = 8'h42;
        ir_ready = 1'b1;
        run();
        chk("rst_addr", rom_address, 8'h00);
        chk("rst_valid", 8'(ir_valid), 8'd0);
        chk("rst_op", ir_opcode, 8'h00);
        chk("rst_arg", ir_operand, 8'h00);
        chk("rst_pc", ir_pc, 8'h00);
        chk("rst_fault", 8'(fetch_fault), 8'd0);
        chk("rst_illegal", 8'(ir_illegal), 8'd0);
        cyc(3);
        chk("seq_c4_valid", 8'(ir_valid), 8'd0);
        cyc(1);
        lit_issue("seq_first", 8'h86, 8'h01, 8'h00);
        cyc(3);
        lit_issue("seq_second", 8'h42, 8'h00, 8'h02);
        // backpressure
        hold_reset();
        rom[0] = 8'h87; rom[1] = 8'hDF;
        ir_ready = 1'b0;
        run();
        cyc(4);
        lit_issue("bp_issue", 8'h87, 8'hDF, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            lit_issue("bp_hold", 8'h87, 8'hDF, 8'h00);
            chk("bp_hold_addr", rom_address, 8'h02);
        end
        ir_ready = 1'b1;
        cyc(1);
        chk("bp_fetch_valid", 8'(ir_valid), 8'd0);
        chk("bp_fetch_addr", rom_address, 8'h02);
        cyc(2);
        lit_issue("bp_next", 8'h42, 8'h00, 8'h02);
        // redirect together with handshake
        hold_reset();
        rom[9] = 8'h20; rom[10] = 8'h04; rom[11] = 8'h43; rom[4] = 8'h96; rom[5] = 8'hDF;
        ir_ready = 1'b0;
        run();
        redirect_en = 1'b1; redirect_addr = 8'h09;
        cyc(1);
        redirect_en = 1'b0;
        chk("rd_addr09", rom_address, 8'h09);
        cyc(4);
        lit_issue("rd_bra", 8'h20, 8'h04, 8'h09);
        ir_ready = 1'b1; redirect_en = 1'b1; redirect_addr = 8'h04;
        cyc(1);
        redirect_en = 1'b0;
        chk("rd_addr04", rom_address, 8'h04);
        chk("rd_valid0", 8'(ir_valid), 8'd0);
        cyc(4);
        lit_issue("rd_target", 8'h96, 8'hDF, 8'h04);
        // boundary fault on the operand byte, then redirects are ignored
        hold_reset();
        rom[127] = 8'h88;
        run();
        redirect_en = 1'b1; redirect_addr = 8'h7F;
        cyc(1);
        redirect_en = 1'b0;
        chk("bf_addr7f", rom_address, 8'h7F);
        cyc(2);
        chk("bf_c4_fault", 8'(fetch_fault), 8'd0);
        cyc(1);
        chk("bf_fault", 8'(fetch_fault), 8'd1);
        chk("bf_valid", 8'(ir_valid), 8'd0);
        redirect_en = 1'b1; redirect_addr = 8'h00;
        cyc(3);
        redirect_en = 1'b0;
        chk("bf_sticky", 8'(fetch_fault), 8'd1);
        chk("bf_sticky_addr", rom_address, 8'h80);
        // 1-byte instructions at the top of the ROM, then PC 80 faults
        hold_reset();
        rom[126] = 8'h42; rom[127] = 8'h4C;
        run();
        redirect_en = 1'b1; redirect_addr = 8'h7E;
        cyc(1);
        redirect_en = 1'b0;
        cyc(2);
        lit_issue("top_7e", 8'h42, 8'h00, 8'h7E);
        cyc(3);
        lit_issue("top_7f", 8'h4C, 8'h00, 8'h7F);
        cyc(1);
        chk("top_addr80", rom_address, 8'h80);
        chk("top_nofault", 8'(fetch_fault), 8'd0);
        cyc(1);
        chk("top_fault", 8'(fetch_fault), 8'd1);
        // direct redirect to 80
        hold_reset();
        run();
        redirect_en = 1'b1; redirect_addr = 8'h80;
        cyc(1);
        redirect_en = 1'b0;
        chk("r80_addr", rom_address, 8'h80);
        chk("r80_nofault", 8'(fetch_fault), 8'd0);
        cyc(1);
        chk("r80_fault", 8'(fetch_fault), 8'd1);
        // undefined opcode
        hold_reset();
        rom[0] = 8'hFF; rom[1] = 8'h42;
        run();
        cyc(2);
        lit_issue("ill_issue", 8'hFF, 8'h00, 8'h00);
        chk("ill_flag", 8'(ir_illegal), 8'(TRAP));
        cyc(1);
        chk("ill_fault", 8'(fetch_fault), 8'(TRAP));
        cyc(2);
        chk("ill_next_valid", 8'(ir_valid), 8'(!TRAP));
        if (!TRAP) lit_issue("ill_next", 8'h42, 8'h00, 8'h01);
        // reset during CAPT_ARG
        hold_reset();
        rom[0] = 8'h86; rom[1] = 8'h01;
        run();
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_addr", rom_address, 8'h00);
        chk("mid_valid", 8'(ir_valid), 8'd0);
        chk("mid_op", ir_opcode, 8'h00);
        chk("mid_arg", ir_operand, 8'h00);
        chk("mid_pc", ir_pc, 8'h00);
        chk("mid_fault", 8'(fetch_fault), 8'd0);
        cyc(4);
        lit_issue("mid_restart", 8'h86, 8'h01, 8'h00);
        // mixed stream with random backpressure and redirects
        hold_reset();
        for (int i = 0; i < 128; i++) rom[i] = tbl[$urandom_range(0, 14)];
        run();
        for (int i = 0; i < 400; i++) begin
            ir_ready = $urandom_range(0, 3) != 0;
            redirect_en = $urandom_range(0, 15) == 0;
            redirect_addr = 8'($urandom_range(0, 127));
            cyc(1);
        end
        redirect_en = 1'b0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
